vga_timing_gen: RTL and testbench

- Raster timing generator that drives the pixel-side interface consumed by sprite/background renderers: DrawX, DrawY, blank, hs, vs.
- Produces 640x480@60 timing from the 25 MHz vga_clk.
- Delays blank and the sync outputs so they line up with the renderers' ROM-plus-output-register pipeline.
- Sits between the clock/reset block and all draw modules; hs/vs go to the VGA pins.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_delay_line.sv | 42 ++++
 rtl/vga_timing_gen.sv | 135 +++++++++++++
 tb/tb_vga_timing_gen.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module : vga_timing_pkg
// Brief  : Default 640x480@60 raster constants and the coordinate type.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    localparam int DEF_H_VIS  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_VIS  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    localparam int DEF_H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_BLANK_DELAY = 1;
    localparam int DEF_SYNC_DELAY  = 2;

endpackage : vga_timing_pkg

`default_nettype wire

// File: rtl/vga_delay_line.sv
// ============================================================================
// Module : vga_delay_line
// Brief  : Enable-qualified 1-bit shift delay of DEPTH (0..4) clocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_delay_line #(
    parameter int   DEPTH     = 1,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_shift
            logic [DEPTH-1:0] stages;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stages <= {DEPTH{RESET_VAL}};
                end else if (en) begin
                    stages[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign q = stages[DEPTH-1];
        end
    endgenerate

endmodule : vga_delay_line

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module : vga_timing_gen
// Brief  : 640x480 raster counters with pipeline-aligned blank/hs/vs.
//          Optional frame counter enabled by defining VGA_FRAME_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VIS       = DEF_H_VIS,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_VIS       = DEF_V_VIS,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int BLANK_DELAY = DEF_BLANK_DELAY,
    parameter int SYNC_DELAY  = DEF_SYNC_DELAY
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        clk_en,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS_C    = coord_t'(H_VIS);
    localparam coord_t V_VIS_C    = coord_t'(V_VIS);
    localparam coord_t HS_START   = coord_t'(H_VIS + H_FP);
    localparam coord_t HS_END     = coord_t'(H_VIS + H_FP + H_SYNC);
    localparam coord_t VS_START   = coord_t'(V_VIS + V_FP);
    localparam coord_t VS_END     = coord_t'(V_VIS + V_FP + V_SYNC);

    coord_t x_cnt;
    coord_t y_cnt;
    logic   x_last;
    logic   y_last;
    logic   blank_raw;
    logic   hs_raw;
    logic   vs_raw;

    assign x_last = (x_cnt == H_LAST);
    assign y_last = (y_cnt == V_LAST);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (clk_en) begin
            if (x_last) begin
                x_cnt <= '0;
                y_cnt <= y_last ? '0 : y_cnt + coord_t'(1);
            end else begin
                x_cnt <= x_cnt + coord_t'(1);
            end
        end
    end

    // Raw decode describes the pixel the counters point at right now; the
    // delay lines shift it to match the renderers' ROM + output register.
    assign blank_raw = (x_cnt < H_VIS_C) && (y_cnt < V_VIS_C);
    assign hs_raw    = !((x_cnt >= HS_START) && (x_cnt < HS_END));
    assign vs_raw    = !((y_cnt >= VS_START) && (y_cnt < VS_END));

    vga_delay_line #(
        .DEPTH     (BLANK_DELAY),
        .RESET_VAL (1'b0)
    ) u_blank_dly (
        .clk   (vga_clk),
        .rst_n (reset_n),
        .en    (clk_en),
        .d     (blank_raw),
        .q     (blank)
    );

    vga_delay_line #(
        .DEPTH     (SYNC_DELAY),
        .RESET_VAL (1'b1)
    ) u_hs_dly (
        .clk   (vga_clk),
        .rst_n (reset_n),
        .en    (clk_en),
        .d     (hs_raw),
        .q     (hs)
    );

    vga_delay_line #(
        .DEPTH     (SYNC_DELAY),
        .RESET_VAL (1'b1)
    ) u_vs_dly (
        .clk   (vga_clk),
        .rst_n (reset_n),
        .en    (clk_en),
        .d     (vs_raw),
        .q     (vs)
    );

    assign DrawX       = x_cnt;
    assign DrawY       = y_cnt;
    assign line_start  = (x_cnt == '0);
    assign frame_start = line_start && (y_cnt == '0);

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
        end else if (clk_en && x_last && y_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign frame_count = frame_cnt;
`else
    assign frame_count = '0;
`endif

endmodule : vga_timing_gen

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module : tb_vga_timing_gen
// Brief  : Scoreboard bench for vga_timing_gen on a reduced raster geometry.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

    localparam int HV = 16, HF = 2, HS = 4, HB = 3;
    localparam int VV = 6,  VF = 2, VS = 2, VB = 3;
    localparam int BD = 1,  SD = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic        clk_en;
    logic [9:0]  DrawX, DrawY;
    logic        blank, hs, vs, line_start, frame_start;
    logic [15:0] frame_count;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .BLANK_DELAY(BD), .SYNC_DELAY(SD)
    ) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .clk_en      (clk_en),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .hs          (hs),
        .vs          (vs),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        b, h, v, ls, fs;
        logic [15:0] fc;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Reference: hx/hy[k] is the raster position k enabled edges ago.
    int hx[0:4], hy[0:4];
    int since;
    int mfc;

    function automatic logic raw_b(int x, int y);
        return (x < HV) && (y < VV);
    endfunction
    function automatic logic raw_h(int x);
        return !((x >= HV + HF) && (x < HV + HF + HS));
    endfunction
    function automatic logic raw_v(int y);
        return !((y >= VV + VF) && (y < VV + VF + VS));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 5; k++) begin
            hx[k] = 0;
            hy[k] = 0;
        end
        since = 0;
        mfc   = 0;
    endtask

    task automatic model_edge();
        int nx, ny;
        if (!clk_en) return;
        nx = hx[0] + 1;
        ny = hy[0];
        if (hx[0] == HT - 1) begin
            nx = 0;
            ny = (hy[0] == VT - 1) ? 0 : hy[0] + 1;
            if (hy[0] == VT - 1) mfc = (mfc + 1) & 16'hFFFF;
        end
        for (int k = 4; k > 0; k--) begin
            hx[k] = hx[k-1];
            hy[k] = hy[k-1];
        end
        hx[0] = nx;
        hy[0] = ny;
        if (since < 10) since++;
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        e.x  = 10'(hx[0]);
        e.y  = 10'(hy[0]);
        e.b  = (since >= BD) ? raw_b(hx[BD], hy[BD]) : 1'b0;
        e.h  = (since >= SD) ? raw_h(hx[SD]) : 1'b1;
        e.v  = (since >= SD) ? raw_v(hy[SD]) : 1'b1;
        e.ls = (hx[0] == 0);
        e.fs = (hx[0] == 0) && (hy[0] == 0);
`ifdef VGA_FRAME_CNT_EN
        e.fc = 16'(mfc);
`else
        e.fc = 16'd0;
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        exp_t e, o;
        @(posedge vga_clk);
        if (reset_n) model_edge();
        sb.push_back(expect_now());
        @(negedge vga_clk);
        e = sb.pop_front();
        o.x = DrawX; o.y = DrawY; o.b = blank; o.h = hs; o.v = vs;
        o.ls = line_start; o.fs = frame_start; o.fc = frame_count;
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL vec obs x=%0d y=%0d b=%b h=%b v=%b ls=%b fs=%b fc=%0d exp x=%0d y=%0d b=%b h=%b v=%b ls=%b fs=%b fc=%0d",
                   o.x, o.y, o.b, o.h, o.v, o.ls, o.fs, o.fc,
                   e.x, e.y, e.b, e.h, e.v, e.ls, e.fs, e.fc);
        end
    endtask

    task automatic run_to(input int tx, input int ty, input int budget);
        int n = 0;
        while (!(DrawX == 10'(tx) && DrawY == 10'(ty)) && n < budget) begin
            tick();
            n++;
        end
        chk("reach_pos", 32'(DrawX == 10'(tx) && DrawY == 10'(ty)), 32'd1);
    endtask

    initial begin
        int hs_fall, hs_low, blank_cnt, first_blank;
        int n, frame_len, ls_bad, last_ls, vs_low, vs_first, k;
        logic [9:0] sx;
        logic sbl, shs;

        // Reset with clock running: outputs at reset values, pulses high.
        reset_n = 1'b0;
        clk_en  = 1'b1;
        model_reset();
        tick();
        tick();
        chk("rst_line_start", 32'(line_start), 32'd1);
        chk("rst_hs", 32'(hs), 32'd1);

        // First line after release: hs fall timing and width, blank window.
        reset_n = 1'b1;
        hs_fall = -1; hs_low = 0; blank_cnt = 0; first_blank = -1;
        for (int i = 1; i <= HT; i++) begin
            tick();
            if (!hs && hs_fall < 0) hs_fall = i;
            if (!hs) hs_low++;
            if (blank) begin
                blank_cnt++;
                if (first_blank < 0) first_blank = i;
            end
        end
        chk("hs_fall_clk", 32'(hs_fall), 32'(HV + HF + SD));
        chk("hs_low_len", 32'(hs_low), 32'(HS));
        chk("blank_first", 32'(first_blank), 32'(BD));
        chk("blank_len", 32'(blank_cnt), 32'(HV));

        // One full frame between frame_start pulses.
        n = 0;
        while (!frame_start && n < 2 * FRAME) begin
            tick();
            n++;
        end
        chk("sync_frame_start", 32'(frame_start), 32'd1);
        frame_len = -1; ls_bad = 0; last_ls = 0; vs_low = 0; vs_first = -1;
        for (k = 1; k <= 2 * FRAME; k++) begin
            tick();
            if (!vs) begin
                vs_low++;
                if (vs_first < 0) vs_first = k;
            end
            if (line_start) begin
                if (k - last_ls != HT) ls_bad++;
                last_ls = k;
            end
            if (frame_start) begin
                frame_len = k;
                break;
            end
        end
        chk("frame_period", 32'(frame_len), 32'(FRAME));
        chk("line_gap_errs", 32'(ls_bad), 32'd0);
        chk("vs_low_len", 32'(vs_low), 32'(VS * HT));
        chk("vs_first_clk", 32'(vs_first), 32'((VV + VF) * HT + SD));

        // Stall for 5 clocks mid-line; hs fall slips by the same amount.
        for (int i = 0; i < 5; i++) tick();
        sx = DrawX; sbl = blank; shs = hs;
        k = 5;
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            k++;
            chk("stall_x", 32'(DrawX), 32'(sx));
            chk("stall_blank", 32'(blank), 32'(sbl));
            chk("stall_hs", 32'(hs), 32'(shs));
        end
        clk_en = 1'b1;
        hs_fall = -1;
        for (int i = 0; i < HT + 10 && hs_fall < 0; i++) begin
            tick();
            k++;
            if (!hs) hs_fall = k;
        end
        chk("stall_hs_fall", 32'(hs_fall), 32'(HV + HF + SD + 5));

        // Asynchronous reset between edges mid-frame.
        run_to(10, 4, 2 * FRAME);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_x", 32'(DrawX), 32'd0);
        chk("arst_y", 32'(DrawY), 32'd0);
        chk("arst_blank", 32'(blank), 32'd0);
        chk("arst_hs", 32'(hs), 32'd1);
        chk("arst_vs", 32'(vs), 32'd1);
        chk("arst_fs", 32'(frame_start), 32'd1);
        chk("arst_fc", 32'(frame_count), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_x", 32'(DrawX), 32'd1);

        // Three frames from reset land on (0,0) of the fourth.
        for (int i = 1; i < 3 * FRAME; i++) tick();
        chk("f4_x", 32'(DrawX), 32'd0);
        chk("f4_y", 32'(DrawY), 32'd0);
`ifdef VGA_FRAME_CNT_EN
        chk("frame_count", 32'(frame_count), 32'd3);
`else
        chk("frame_count", 32'(frame_count), 32'd0);
`endif

        // Raster wrap boundary.
        run_to(HT - 1, VT - 1, 2 * FRAME);
        tick();
        chk("wrap_x", 32'(DrawX), 32'd0);
        chk("wrap_y", 32'(DrawY), 32'd0);
        chk("wrap_fs", 32'(frame_start), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_vga_timing_gen

`default_nettype wire
